// File: rtl/sevseg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
// A blanking gap opens each digit slot, and a double-buffered value is committed only at frame boundaries.
module sevseg_scan_ctrl #(
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] value_in_i,
    input  logic        load_i,
    input  logic        lz_en_i,
    input  logic [3:0]  dp_in_i,
    input  logic [3:0]  en_i,
    output logic [3:0]  x_o,
    output logic [3:0]  an_o,
    output logic        dp_o,
    output logic [1:0]  digit_sel_o,
    output logic        pending_o,
    output logic        frame_start_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC - 1);

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  digit_q, digit_d;
    logic [15:0] active_q, active_d;
    logic [15:0] shadow_q, shadow_d;
    logic        pending_q, pending_d;
    logic        frame_q, frame_d;
    logic [3:0]  x_q, x_d;
    logic [3:0]  an_q, an_d;
    logic        dp_q, dp_d;
    logic        wrap;
    logic        suppressed;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= BLANK;
            cnt_q     <= '0;
            digit_q   <= 2'd0;
            active_q  <= 16'h0000;
            shadow_q  <= 16'h0000;
            pending_q <= 1'b0;
            frame_q   <= 1'b0;
            x_q       <= 4'h0;
            an_q      <= 4'hF;
            dp_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            frame_q   <= frame_d;
            x_q       <= x_d;
            an_q      <= an_d;
            dp_q      <= dp_d;
        end
    end

    // Slot sequencing plus the shadow/active handshake; a load on the wrap edge bypasses the shadow.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        digit_d   = digit_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        wrap      = 1'b0;

        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_END) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    digit_d = digit_q + 2'd1;
                    state_d = BLANK;
                    wrap    = (digit_q == 2'd3);
                end
            end
            default: state_d = BLANK;
        endcase

        if (load_i) begin
            shadow_d  = value_in_i;
            pending_d = 1'b1;
        end

        if (wrap) begin
            if (load_i) begin
                active_d = value_in_i;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
            pending_d = 1'b0;
        end

        frame_d = wrap;
    end

    // Outputs are computed from the next state so the registered values line up with the slot they describe.
    always_comb begin
        x_d        = 4'h0;
        suppressed = 1'b0;
        an_d       = 4'hF;
        dp_d       = 1'b1;

        case (digit_d)
            2'd0: x_d = active_d[3:0];
            2'd1: x_d = active_d[7:4];
            2'd2: x_d = active_d[11:8];
            default: x_d = active_d[15:12];
        endcase

        case (digit_d)
            2'd3: suppressed = lz_en_i && (active_d[15:12] == 4'h0);
            2'd2: suppressed = lz_en_i && (active_d[15:8] == 8'h00);
            2'd1: suppressed = lz_en_i && (active_d[15:4] == 12'h000);
            default: suppressed = 1'b0;
        endcase

        if ((state_d == SHOW) && en_i[digit_d] && !suppressed) begin
            an_d[digit_d] = 1'b0;
            dp_d          = ~dp_in_i[digit_d];
        end
    end

    assign x_o           = x_q;
    assign an_o          = an_q;
    assign dp_o          = dp_q;
    assign digit_sel_o   = digit_q;
    assign pending_o     = pending_q;
    assign frame_start_o = frame_q;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Randomized bench for sevseg_scan_ctrl: a cycle-indexed arithmetic model of the scan
// predicts every output each cycle, with literal spot values pinning the model.
module tb_sevseg_scan_ctrl;

    localparam int TD = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * TD;

    logic        clk;
    logic        reset;
    logic [15:0] value_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  dp_in;
    logic [3:0]  en;
    logic [3:0]  x;
    logic [3:0]  an;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        pending;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    // Model state: t is the cycle index since reset release
    int          t;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    bit          m_pending;
    bit          m_frame;
    logic [3:0]  m_en;
    logic [3:0]  m_dp;
    bit          m_lz;

    sevseg_scan_ctrl #(
        .TICK_DIV (TD),
        .BLANK_CYC(BC)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .value_in_i   (value_in),
        .load_i       (load),
        .lz_en_i      (lz_en),
        .dp_in_i      (dp_in),
        .en_i         (en),
        .x_o          (x),
        .an_o         (an),
        .dp_o         (dp),
        .digit_sel_o  (digit_sel),
        .pending_o    (pending),
        .frame_start_o(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s t=%0d got %h expected %h", name, t, act, exp);
        end
    endtask

    // A digit is dark under suppression when it and every more significant nibble are zero
    function automatic bit isSuppressed(input logic [15:0] val, input int d, input bit lz);
        return lz && (d != 0) && ((val >> (4 * d)) == 16'h0000);
    endfunction

    task automatic checkOutput();
        int d;
        int pos;
        bit lit;
        logic [3:0] ex;
        logic [3:0] ean;
        logic edp;
        d   = (t / TD) % 4;
        pos = t % TD;
        ex  = 4'((m_active >> (4 * d)) & 16'h000F);
        lit = (pos >= BC) && m_en[d] && !isSuppressed(m_active, d, m_lz);
        ean = 4'hF;
        edp = 1'b1;
        if (lit) begin
            ean[d] = 1'b0;
            edp    = ~m_dp[d];
        end
        cmp("x", {12'h0, x}, {12'h0, ex});
        cmp("an", {12'h0, an}, {12'h0, ean});
        cmp("dp", {15'h0, dp}, {15'h0, edp});
        cmp("digit_sel", {14'h0, digit_sel}, 16'(d));
        cmp("pending", {15'h0, pending}, {15'h0, m_pending});
        cmp("frame_start", {15'h0, frame_start}, {15'h0, m_frame});
    endtask

    task automatic modelEdge();
        bit wrap;
        wrap = ((t + 1) % FRAME) == 0;
        if (wrap) begin
            if (load) m_active = value_in;
            else if (m_pending) m_active = m_shadow;
            m_pending = 1'b0;
        end else if (load) begin
            m_pending = 1'b1;
        end
        if (load) m_shadow = value_in;
        m_frame = wrap;
        m_en    = en;
        m_dp    = dp_in;
        m_lz    = lz_en;
    endtask

    task automatic applyStimulus(input bit l, input logic [15:0] v, input logic [3:0] e,
                                 input bit z, input logic [3:0] p);
        load     = l;
        value_in = v;
        en       = e;
        lz_en    = z;
        dp_in    = p;
        modelEdge();
        @(posedge clk);
        #1;
        t++;
        checkOutput();
    endtask

    task automatic doReset();
        load  = 1'b0;
        reset = 1'b1;
        #1;
        cmp("rst_an", {12'h0, an}, 16'h000F);
        cmp("rst_dp", {15'h0, dp}, 16'h0001);
        cmp("rst_x", {12'h0, x}, 16'h0000);
        cmp("rst_digit", {14'h0, digit_sel}, 16'h0000);
        cmp("rst_pending", {15'h0, pending}, 16'h0000);
        cmp("rst_frame", {15'h0, frame_start}, 16'h0000);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        t         = 0;
        m_active  = 16'h0;
        m_shadow  = 16'h0;
        m_pending = 1'b0;
        m_frame   = 1'b0;
        m_en      = 4'h0;
        m_dp      = 4'h0;
        m_lz      = 1'b0;
        checkOutput();
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        value_in = 16'h0;
        lz_en    = 1'b0;
        dp_in    = 4'h0;
        en       = 4'hF;
        t        = 0;
        repeat (2) @(posedge clk);
        #1;

        // Plain scan plus a load committed at the frame boundary
        doReset();
        while (t < 40) begin
            applyStimulus(t == 5, 16'h1A2F, 4'hF, 1'b0, 4'h0);
            if (t == 1)  cmp("lit_an_c1", {12'h0, an}, 16'h000F);
            if (t == 2)  cmp("lit_an_c2", {12'h0, an}, 16'h000E);
            if (t == 6)  cmp("lit_pend_c6", {15'h0, pending}, 16'h0001);
            if (t == 8)  cmp("lit_an_c8", {12'h0, an}, 16'h000F);
            if (t == 10) cmp("lit_an_c10", {12'h0, an}, 16'h000D);
            if (t == 26) cmp("lit_an_c26", {12'h0, an}, 16'h0007);
            if (t == 31) cmp("lit_x_c31", {12'h0, x}, 16'h0000);
            if (t == 32) begin
                cmp("lit_x_c32", {12'h0, x}, 16'h000F);
                cmp("lit_frame_c32", {15'h0, frame_start}, 16'h0001);
                cmp("lit_pend_c32", {15'h0, pending}, 16'h0000);
            end
            if (t == 33) cmp("lit_frame_c33", {15'h0, frame_start}, 16'h0000);
        end

        // Load coincident with the wrap edge wins over an earlier pending load
        doReset();
        while (t < 40) begin
            applyStimulus((t == 4) || (t == 31), (t == 4) ? 16'h1234 : 16'h5678, 4'hF, 1'b0, 4'h0);
            if (t == 5)  cmp("lit_pend_c5", {15'h0, pending}, 16'h0001);
            if (t == 32) begin
                cmp("lit_x_wrap", {12'h0, x}, 16'h0008);
                cmp("lit_pend_wrap", {15'h0, pending}, 16'h0000);
            end
            if (t == 40) cmp("lit_x_c40", {12'h0, x}, 16'h0007);
        end

        // Leading-zero suppression with 0042 and then with zero
        while (t < 110) begin
            applyStimulus((t == 63) || (t == 95), (t == 63) ? 16'h0042 : 16'h0000, 4'hF, 1'b1, 4'h0);
            if (t == 66) cmp("lit_lz_d0", {12'h0, an}, 16'h000E);
            if (t == 74) cmp("lit_lz_d1", {12'h0, an}, 16'h000D);
            if (t == 82) cmp("lit_lz_d2", {12'h0, an}, 16'h000F);
            if (t == 90) cmp("lit_lz_d3", {12'h0, an}, 16'h000F);
            if (t == 98) cmp("lit_zero_d0", {12'h0, an}, 16'h000E);
            if (t == 106) cmp("lit_zero_d1", {12'h0, an}, 16'h000F);
        end

        // Digit mask and decimal points
        while (t < 160) begin
            applyStimulus(1'b0, 16'h0, 4'b1011, 1'b0, 4'b0010);
            if (t == 130) cmp("lit_dp_d0", {15'h0, dp}, 16'h0001);
            if (t == 136) cmp("lit_dp_blank", {15'h0, dp}, 16'h0001);
            if (t == 138) cmp("lit_dp_d1", {15'h0, dp}, 16'h0000);
            if (t == 146) cmp("lit_mask_d2", {12'h0, an}, 16'h000F);
        end

        // Reset mid-frame with a pending value that must be discarded
        doReset();
        while (t < 19) begin
            applyStimulus(t == 5, 16'hBEEF, 4'hF, 1'b0, 4'h0);
        end
        cmp("lit_pend_pre", {15'h0, pending}, 16'h0001);
        doReset();
        while (t < 40) begin
            applyStimulus(1'b0, 16'h0, 4'hF, 1'b0, 4'h0);
            if (t == 2)  cmp("lit_restart_an", {12'h0, an}, 16'h000E);
            if (t == 32) cmp("lit_restart_x", {12'h0, x}, 16'h0000);
        end

        // Randomized traffic with an occasional reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 777) doReset();
            applyStimulus($urandom_range(0, 11) == 0, 16'($urandom),
                          4'($urandom), ((i / 64) % 2) == 1, 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
